// File: rtl/cfu_pkg.sv
// Function ids and sequencer state encoding shared by the CFU N-queens master
// and its transaction unit.
package cfu_pkg;
    localparam int unsigned FID_W = 10;

    localparam logic [FID_W-1:0] CFU_INIT    = 10'd0;
    localparam logic [FID_W-1:0] CFU_KERNEL  = 10'd1;
    localparam logic [FID_W-1:0] CFU_GET_RET = 10'd2;

    typedef enum logic [3:0] {
        IDLE,
        INIT_CMD,
        INIT_RSP,
        KERN_CMD,
        KERN_RSP,
        RET_CMD,
        RET_RSP,
        NEXT,
        FIN
    } state_e;
endpackage

// File: rtl/cfu_xact.sv
// Single CFU transaction: presents one command while requested, tracks the
// outstanding response and strobes the response data back to the sequencer.
module cfu_xact
    import cfu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_i,
    input  logic [FID_W-1:0] fid_i,
    input  logic [31:0]      in0_i,
    output logic             cmd_valid_o,
    input  logic             cmd_ready_i,
    output logic [FID_W-1:0] cmd_fid_o,
    output logic [31:0]      cmd_in0_o,
    input  logic             rsp_valid_i,
    output logic             rsp_ready_o,
    input  logic [31:0]      rsp_data_i,
    output logic             sent_o,
    output logic             rsp_strobe_o,
    output logic [31:0]      rsp_data_o
);
    logic wait_q;
    logic wait_d;
    logic fire;

    // req_i comes straight from registered sequencer state, so the command
    // and its payload stay put until the sequencer sees the transfer.
    assign cmd_valid_o  = req_i && !wait_q;
    assign cmd_fid_o    = fid_i;
    assign cmd_in0_o    = in0_i;
    assign fire         = cmd_valid_o && cmd_ready_i;
    assign rsp_ready_o  = req_i || wait_q;
    assign rsp_strobe_o = rsp_valid_i && rsp_ready_o && (fire || wait_q);
    assign sent_o       = fire && !rsp_strobe_o;
    assign rsp_data_o   = rsp_data_i;

    always_comb begin
        wait_d = wait_q;
        if (rsp_strobe_o) begin
            wait_d = 1'b0;
        end else if (fire) begin
            wait_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= wait_d;
        end
    end
endmodule

// File: rtl/cfu_nq_master.sv
// Sweeps N-queens start columns through a CFU: INIT per column, KERNEL until
// the CFU reports zero, then GET_RET accumulated into result.
module cfu_nq_master
    import cfu_pkg::*;
#(
    parameter logic [31:0] MAX_KERNEL = 32'h0400_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [4:0]  col_lo,
    input  logic [4:0]  col_hi,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] result,
    output logic [31:0] kernel_cnt,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0
);
    state_e      state_q;
    logic [4:0]  col_q;
    logic [4:0]  col_hi_q;
    logic [31:0] kcol_q;
    logic [31:0] result_q;
    logic [31:0] kernel_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic             xact_req;
    logic [FID_W-1:0] xact_fid;
    logic [31:0]      xact_in0;
    logic             xact_sent;
    logic             xact_rsp;
    logic [31:0]      xact_data;

    always_comb begin
        xact_req = 1'b0;
        xact_fid = CFU_INIT;
        xact_in0 = '0;
        case (state_q)
            INIT_CMD: begin
                xact_req = 1'b1;
                xact_in0 = {27'd0, col_q};
            end
            KERN_CMD: begin
                xact_req = 1'b1;
                xact_fid = CFU_KERNEL;
            end
            RET_CMD: begin
                xact_req = 1'b1;
                xact_fid = CFU_GET_RET;
            end
            default: ;
        endcase
    end

    cfu_xact u_xact (
        .clk          (clk),
        .rst_n        (reset_n),
        .req_i        (xact_req),
        .fid_i        (xact_fid),
        .in0_i        (xact_in0),
        .cmd_valid_o  (cmd_valid),
        .cmd_ready_i  (cmd_ready),
        .cmd_fid_o    (cmd_payload_function_id),
        .cmd_in0_o    (cmd_payload_inputs_0),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .rsp_data_i   (rsp_payload_outputs_0),
        .sent_o       (xact_sent),
        .rsp_strobe_o (xact_rsp),
        .rsp_data_o   (xact_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            col_hi_q     <= '0;
            kcol_q       <= '0;
            result_q     <= '0;
            kernel_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q       <= 1'b1;
                        error_q      <= 1'b0;
                        result_q     <= '0;
                        kernel_cnt_q <= '0;
                        col_q        <= col_lo;
                        col_hi_q     <= col_hi;
                        state_q      <= (col_lo > col_hi) ? FIN : INIT_CMD;
                    end
                end
                INIT_CMD, INIT_RSP: begin
                    if (xact_rsp) begin
                        kcol_q  <= '0;
                        state_q <= KERN_CMD;
                    end else if (xact_sent) begin
                        state_q <= INIT_RSP;
                    end
                end
                KERN_CMD, KERN_RSP: begin
                    if (xact_rsp) begin
                        kernel_cnt_q <= kernel_cnt_q + 32'd1;
                        kcol_q       <= kcol_q + 32'd1;
                        // A zero reply always finishes the column, even on the last allowed kernel.
                        if (xact_data == '0) begin
                            state_q <= RET_CMD;
                        end else if (kcol_q + 32'd1 >= MAX_KERNEL) begin
                            error_q <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= KERN_CMD;
                        end
                    end else if (xact_sent) begin
                        state_q <= KERN_RSP;
                    end
                end
                RET_CMD, RET_RSP: begin
                    if (xact_rsp) begin
                        result_q <= result_q + xact_data;
                        state_q  <= NEXT;
                    end else if (xact_sent) begin
                        state_q <= RET_RSP;
                    end
                end
                NEXT: begin
                    if (col_q == col_hi_q) begin
                        state_q <= FIN;
                    end else begin
                        col_q   <= col_q + 5'd1;
                        state_q <= INIT_CMD;
                    end
                end
                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign result               = result_q;
    assign kernel_cnt           = kernel_cnt_q;
    assign cmd_payload_inputs_1 = '0;
endmodule

// File: tb/tb_cfu_nq_master.sv
// Directed bench for cfu_nq_master with an N=8 CFU responder model that can run
// combinationally or with random ready stalls and response latency.
module tb_cfu_nq_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic [4:0]  col_lo;
    logic [4:0]  col_hi;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [31:0] kernel_cnt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    cfu_nq_master #(.MAX_KERNEL(32'd10)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .start                   (start),
        .col_lo                  (col_lo),
        .col_hi                  (col_hi),
        .busy                    (busy),
        .done                    (done),
        .error                   (error),
        .result                  (result),
        .kernel_cnt              (kernel_cnt),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Responder configuration and bookkeeping
    logic        comb_mode = 1'b1;
    logic        always1   = 1'b0;
    int unsigned stall_max = 0;
    int unsigned lat_min   = 0;
    int unsigned lat_max   = 0;
    int n_cmds, n_init, n_init3, n_stalls, stab_err, proto_err;

    logic        pend_q;
    int unsigned lat_q;
    int unsigned stall_q;
    logic [31:0] rdata_q;
    logic [9:0]  last_fid;
    logic [31:0] m_col;
    logic [31:0] m_k;
    logic        prev_stalled;
    logic [9:0]  prev_fid;
    logic [31:0] prev_in0;

    // Solutions of 8-queens with the first-row queen in column c.
    function automatic logic [31:0] sol_cnt(input logic [31:0] c);
        case (c)
            32'd0, 32'd7: return 32'd4;
            32'd1, 32'd6: return 32'd8;
            32'd2, 32'd5: return 32'd16;
            32'd3, 32'd4: return 32'd18;
            default:      return 32'd0;
        endcase
    endfunction

    // KERNEL replies nonzero (col+2) times per column, then zero.
    function automatic logic [31:0] model_rsp(input logic [9:0] fid, input logic [31:0] mcol,
                                              input logic [31:0] mk, input logic a1);
        if (fid == 10'd0) return 32'd0;
        if (fid == 10'd1) begin
            if (a1) return 32'd1;
            return (mk < mcol + 32'd2) ? mk + 32'd1 : 32'd0;
        end
        if (fid == 10'd2) return sol_cnt(mcol);
        return 32'hBAD0_0000;
    endfunction

    assign cmd_ready = comb_mode ? rsp_ready : (!pend_q && stall_q == 0);
    assign rsp_valid = comb_mode ? cmd_valid : (pend_q && lat_q == 0);
    assign rsp_payload_outputs_0 = comb_mode ?
        model_rsp(cmd_payload_function_id, m_col, m_k, always1) : rdata_q;

    always @(posedge clk) begin
        if (!reset_n) begin
            pend_q       <= 1'b0;
            lat_q        <= 0;
            stall_q      <= 0;
            prev_stalled <= 1'b0;
        end else begin
            if (cmd_valid && !cmd_ready) n_stalls++;
            if (prev_stalled && (!cmd_valid || cmd_payload_function_id !== prev_fid ||
                                 cmd_payload_inputs_0 !== prev_in0)) stab_err++;
            prev_stalled <= cmd_valid && !cmd_ready;
            prev_fid     <= cmd_payload_function_id;
            prev_in0     <= cmd_payload_inputs_0;
            if (cmd_valid && cmd_ready) begin
                n_cmds++;
                if (cmd_payload_function_id == 10'd0) begin
                    n_init++;
                    if (cmd_payload_inputs_0 == 32'd3) n_init3++;
                end
                if (cmd_payload_function_id > 10'd2 || cmd_payload_inputs_1 !== 32'd0) proto_err++;
                rdata_q  <= model_rsp(cmd_payload_function_id, m_col, m_k, always1);
                last_fid <= cmd_payload_function_id;
                if (cmd_payload_function_id == 10'd0) begin
                    m_col <= cmd_payload_inputs_0;
                    m_k   <= 32'd0;
                end else if (cmd_payload_function_id == 10'd1) begin
                    m_k <= m_k + 32'd1;
                end
                if (!comb_mode) begin
                    pend_q  <= 1'b1;
                    lat_q   <= $urandom_range(lat_max, lat_min);
                    stall_q <= $urandom_range(stall_max, 0);
                end
            end else if (stall_q != 0) begin
                stall_q <= stall_q - 1;
            end
            if (pend_q && lat_q != 0) lat_q <= lat_q - 1;
            if (!comb_mode && rsp_valid && rsp_ready) pend_q <= 1'b0;
        end
    end

    task automatic clear_counts();
        n_cmds = 0; n_init = 0; n_init3 = 0; n_stalls = 0; stab_err = 0; proto_err = 0;
    endtask

    // Pulses start and watches done (bounded); first = cycles from start to the first done.
    task automatic run_sweep(input logic [4:0] lo, input logic [4:0] hi,
                             output int first, output int ndone);
        first = 0;
        ndone = 0;
        @(negedge clk);
        col_lo = lo; col_hi = hi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 20000; i++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
            if (first != 0 && i >= first + 5) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
        n_checks++; if (rsp_ready !== 1'b0) $display("FAIL reset_rsp_ready: got %b want 0", rsp_ready); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL reset_result: got %0d want 0", result); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd0) $display("FAIL reset_kernel_cnt: got %0d want 0", kernel_cnt); else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL post_reset_cmd: got %b want 0", cmd_valid); else n_pass++;
    endtask

    task automatic test_full_sweep();
        int first, nd;
        comb_mode = 1'b1; always1 = 1'b0;
        clear_counts();
        run_sweep(5'd0, 5'd7, first, nd);
        n_checks++; if (nd !== 1) $display("FAIL full_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (result !== 32'd92) $display("FAIL full_result: got %0d want 92", result); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL full_error: got %b want 0", error); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd52) $display("FAIL full_kernel_cnt: got %0d want 52", kernel_cnt); else n_pass++;
        n_checks++; if (n_cmds !== 68) $display("FAIL full_cmd_count: got %0d want 68", n_cmds); else n_pass++;
        n_checks++; if (proto_err !== 0) $display("FAIL full_bad_fid_or_in1: got %0d want 0", proto_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL full_busy_after: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_col();
        int first, nd;
        comb_mode = 1'b1; always1 = 1'b0;
        clear_counts();
        run_sweep(5'd3, 5'd3, first, nd);
        n_checks++; if (nd !== 1) $display("FAIL single_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (result !== 32'd18) $display("FAIL single_result: got %0d want 18", result); else n_pass++;
        n_checks++; if (n_init !== 1) $display("FAIL single_init_count: got %0d want 1", n_init); else n_pass++;
        n_checks++; if (n_init3 !== 1) $display("FAIL single_init_col3: got %0d want 1", n_init3); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd6) $display("FAIL single_kernel_cnt: got %0d want 6", kernel_cnt); else n_pass++;
        n_checks++; if (n_cmds !== 8) $display("FAIL single_cmd_count: got %0d want 8", n_cmds); else n_pass++;
    endtask

    task automatic test_empty_range();
        int first, nd;
        comb_mode = 1'b1; always1 = 1'b0;
        clear_counts();
        run_sweep(5'd5, 5'd2, first, nd);
        n_checks++; if (first !== 2) $display("FAIL empty_done_latency: got %0d want 2", first); else n_pass++;
        n_checks++; if (nd !== 1) $display("FAIL empty_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL empty_result: got %0d want 0", result); else n_pass++;
        n_checks++; if (n_cmds !== 0) $display("FAIL empty_cmd_count: got %0d want 0", n_cmds); else n_pass++;
        n_checks++; if (error !== 1'b0) $display("FAIL empty_error: got %b want 0", error); else n_pass++;
    endtask

    task automatic test_stalls();
        int first, nd;
        @(negedge clk);
        comb_mode = 1'b0; always1 = 1'b0; stall_max = 5; lat_min = 0; lat_max = 3;
        clear_counts();
        run_sweep(5'd0, 5'd7, first, nd);
        n_checks++; if (nd !== 1) $display("FAIL stall_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (result !== 32'd92) $display("FAIL stall_result: got %0d want 92", result); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd52) $display("FAIL stall_kernel_cnt: got %0d want 52", kernel_cnt); else n_pass++;
        n_checks++; if (stab_err !== 0) $display("FAIL stall_payload_stable: got %0d changes want 0", stab_err); else n_pass++;
        n_checks++; if (n_stalls == 0) $display("FAIL stall_seen: got %0d stalled cycles want >0", n_stalls); else n_pass++;
        n_checks++; if (proto_err !== 0) $display("FAIL stall_bad_fid_or_in1: got %0d want 0", proto_err); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        int  first, nd;
        logic hit;
        comb_mode = 1'b0; always1 = 1'b0; stall_max = 0; lat_min = 3; lat_max = 3;
        @(negedge clk);
        col_lo = 5'd0; col_hi = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (pend_q && last_fid == 10'd1 && !rsp_valid) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (hit !== 1'b1) $display("FAIL midflight_reach_kern_rsp: got %b want 1", hit); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL midflight_busy_before: got %b want 1", busy); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++; if (cmd_valid !== 1'b0) $display("FAIL midflight_cmd_valid: got %b want 0", cmd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midflight_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rsp_ready !== 1'b0) $display("FAIL midflight_rsp_ready: got %b want 0", rsp_ready); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL midflight_result: got %0d want 0", result); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd0) $display("FAIL midflight_kernel_cnt: got %0d want 0", kernel_cnt); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        comb_mode = 1'b1;
        @(negedge clk);
        clear_counts();
        run_sweep(5'd3, 5'd3, first, nd);
        n_checks++; if (nd !== 1) $display("FAIL restart_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (result !== 32'd18) $display("FAIL restart_result: got %0d want 18", result); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd6) $display("FAIL restart_kernel_cnt: got %0d want 6", kernel_cnt); else n_pass++;
    endtask

    task automatic test_timeout();
        int first, nd;
        comb_mode = 1'b1; always1 = 1'b1;
        clear_counts();
        run_sweep(5'd0, 5'd7, first, nd);
        n_checks++; if (nd !== 1) $display("FAIL timeout_done_pulses: got %0d want 1", nd); else n_pass++;
        n_checks++; if (error !== 1'b1) $display("FAIL timeout_error_held: got %b want 1", error); else n_pass++;
        n_checks++; if (kernel_cnt !== 32'd10) $display("FAIL timeout_kernel_cnt: got %0d want 10", kernel_cnt); else n_pass++;
        n_checks++; if (n_cmds !== 11) $display("FAIL timeout_cmd_count: got %0d want 11", n_cmds); else n_pass++;
        n_checks++; if (result !== 32'd0) $display("FAIL timeout_result: got %0d want 0", result); else n_pass++;
        always1 = 1'b0;
        clear_counts();
        run_sweep(5'd3, 5'd3, first, nd);
        n_checks++; if (error !== 1'b0) $display("FAIL timeout_error_cleared: got %b want 0", error); else n_pass++;
        n_checks++; if (result !== 32'd18) $display("FAIL timeout_recover_result: got %0d want 18", result); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        col_lo  = '0;
        col_hi  = '0;
        test_reset();
        test_full_sweep();
        test_single_col();
        test_empty_range();
        test_stalls();
        test_reset_midflight();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
